// File: rtl/padded_row_window.sv
// Rotating three-row window (top/mid/bot) with zero rows padded above the first and below the last image row.
// Optional build macro PADDED_ROW_WINDOW_FASTPATH_EN lets EMIT accept the next row while handing off a window.
module padded_row_window #(
  parameter int PIX_W   = 8,
  parameter int ROW_LEN = 418,
  parameter int CH      = 3,
  parameter int IMG_H   = 416,
  localparam int ROW_BITS = CH * ROW_LEN * PIX_W,
  localparam int IDX_W    = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROW_BITS-1:0] in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROW_BITS-1:0] out_top,
  output logic [ROW_BITS-1:0] out_mid,
  output logic [ROW_BITS-1:0] out_bot,
  output logic [IDX_W-1:0]    out_row_idx,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD0 = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_H - 1);
  localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(IMG_H - 2);

  logic [2:0]          state_r;
  logic [2:0]          state_nxt_s;
  logic [ROW_BITS-1:0] top_r;
  logic [ROW_BITS-1:0] mid_r;
  logic [ROW_BITS-1:0] bot_r;
  logic [ROW_BITS-1:0] top_nxt_s;
  logic [ROW_BITS-1:0] mid_nxt_s;
  logic [ROW_BITS-1:0] bot_nxt_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                done_r;
  logic                in_ready_s;
  logic                in_xfer_s;
  logic                out_xfer_s;

`ifdef PADDED_ROW_WINDOW_FASTPATH_EN
  logic more_rows_s;

  // EMIT may also take a row, but only while image rows remain to be fetched.
  assign more_rows_s = (idx_r < PEN_IDX);
  assign in_ready_s  = in_ready_r | ((state_r == ST_EMIT) & more_rows_s & out_ready);
`else
  assign in_ready_s  = in_ready_r;
`endif

  assign in_xfer_s  = in_valid & in_ready_s;
  assign out_xfer_s = out_valid_r & out_ready;

  // Next-state and next-window computation.
  always_comb begin
    state_nxt_s = state_r;
    top_nxt_s   = top_r;
    mid_nxt_s   = mid_r;
    bot_nxt_s   = bot_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          top_nxt_s   = {ROW_BITS{1'b0}};
          mid_nxt_s   = {ROW_BITS{1'b0}};
          bot_nxt_s   = {ROW_BITS{1'b0}};
          idx_nxt_s   = {IDX_W{1'b0}};
          state_nxt_s = ST_LOAD0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD0: begin
        if (in_xfer_s) begin
          mid_nxt_s   = in_row;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_LOAD0;
        end
      end
      ST_LOAD: begin
        if (in_xfer_s) begin
          bot_nxt_s   = in_row;
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_EMIT: begin
        if (!out_xfer_s) begin
          state_nxt_s = ST_EMIT;
        end else if (idx_r == LAST_IDX) begin
          state_nxt_s = ST_DONE;
        end else begin
          top_nxt_s = mid_r;
          mid_nxt_s = bot_r;
          idx_nxt_s = idx_r + IDX_W'(1);
          // The window after the penultimate one is the bottom pad: no row to fetch.
          if (idx_r == PEN_IDX) begin
            bot_nxt_s   = {ROW_BITS{1'b0}};
            state_nxt_s = ST_EMIT;
          end else if (in_xfer_s) begin
            bot_nxt_s   = in_row;
            state_nxt_s = ST_EMIT;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, window registers and the flag outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      top_r       <= {ROW_BITS{1'b0}};
      mid_r       <= {ROW_BITS{1'b0}};
      bot_r       <= {ROW_BITS{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      top_r       <= top_nxt_s;
      mid_r       <= mid_nxt_s;
      bot_r       <= bot_nxt_s;
      idx_r       <= idx_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_LOAD0) | (state_nxt_s == ST_LOAD);
      out_valid_r <= (state_nxt_s == ST_EMIT);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_top     = top_r;
  assign out_mid     = mid_r;
  assign out_bot     = bot_r;
  assign out_row_idx = idx_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule
